// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters, pixel requests and a
// PIPE_LAT-aligned sync/DE/colour output stage. Macro VGA_TEST_PATTERN_EN swaps client colour for 8 vertical bars.
module vga_timing_gen #(
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   H_VIS    = 640,
    parameter int   H_FP     = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   V_VIS    = 480,
    parameter int   V_FP     = 10,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   COLOR_W  = 4,
    parameter int   CNT_W    = 10,
    parameter int   PIPE_LAT = 1
) (
    input  logic               clk_vga,
    input  logic               rst_vga,
    input  logic [COLOR_W-1:0] i_r,
    input  logic [COLOR_W-1:0] i_g,
    input  logic [COLOR_W-1:0] i_b,
    output logic               o_req,
    output logic [CNT_W-1:0]   o_x,
    output logic [CNT_W-1:0]   o_y,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic               o_vga_hs,
    output logic               o_vga_vs,
    output logic               o_vga_de,
    output logic [COLOR_W-1:0] o_vga_r,
    output logic [COLOR_W-1:0] o_vga_g,
    output logic [COLOR_W-1:0] o_vga_b
);
    localparam int H_TOT = H_SYNC + H_BP + H_VIS + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_VIS + V_FP;

    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_SYNC + H_BP + H_VIS);
    localparam logic [CNT_W-1:0] H_MAX_C   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_SYNC + V_BP + V_VIS);
    localparam logic [CNT_W-1:0] V_MAX_C   = CNT_W'(V_TOT - 1);

    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q + CNT_W'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_MAX_C) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_MAX_C) ? '0 : vcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst_vga) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Request-side outputs are forced idle while reset is held, even though the counters already read zero.
    logic h_vis, v_vis, req, raw_hs, raw_vs;
    assign h_vis  = (hcnt_q >= H_START_C) && (hcnt_q < H_END_C);
    assign v_vis  = (vcnt_q >= V_START_C) && (vcnt_q < V_END_C);
    assign req    = h_vis && v_vis && !rst_vga;
    assign raw_hs = (hcnt_q < H_SYNC_C) ? HS_POL : ~HS_POL;
    assign raw_vs = (vcnt_q < V_SYNC_C) ? VS_POL : ~VS_POL;

    assign o_req         = req;
    assign o_x           = req ? hcnt_q - H_START_C : '0;
    assign o_y           = req ? vcnt_q - V_START_C : '0;
    assign o_line_start  = !rst_vga && (hcnt_q == '0);
    assign o_frame_start = o_line_start && (vcnt_q == '0);

    logic [PIPE_LAT-1:0] hs_pipe_q, vs_pipe_q, de_pipe_q;

    always_ff @(posedge clk_vga) begin
        if (rst_vga) begin
            hs_pipe_q <= {PIPE_LAT{~HS_POL}};
            vs_pipe_q <= {PIPE_LAT{~VS_POL}};
            de_pipe_q <= '0;
        end else begin
            hs_pipe_q[0] <= raw_hs;
            vs_pipe_q[0] <= raw_vs;
            de_pipe_q[0] <= req;
            for (int i = 1; i < PIPE_LAT; i++) begin
                hs_pipe_q[i] <= hs_pipe_q[i-1];
                vs_pipe_q[i] <= vs_pipe_q[i-1];
                de_pipe_q[i] <= de_pipe_q[i-1];
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Bar index travels with DE so the pattern lines up exactly like client colour would.
    localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(H_VIS / 8);
    logic [2:0] bar_raw;
    logic [2:0] bar_pipe_q [PIPE_LAT];
    assign bar_raw = 3'(o_x / BAR_W_C);

    always_ff @(posedge clk_vga) begin
        if (rst_vga) begin
            for (int i = 0; i < PIPE_LAT; i++) bar_pipe_q[i] <= '0;
        end else begin
            bar_pipe_q[0] <= bar_raw;
            for (int i = 1; i < PIPE_LAT; i++) bar_pipe_q[i] <= bar_pipe_q[i-1];
        end
    end
`endif

    logic               de_last;
    logic [COLOR_W-1:0] r_d, g_d, b_d;
    assign de_last = de_pipe_q[PIPE_LAT-1];

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (de_last) begin
`ifdef VGA_TEST_PATTERN_EN
            r_d = {COLOR_W{bar_pipe_q[PIPE_LAT-1][2]}};
            g_d = {COLOR_W{bar_pipe_q[PIPE_LAT-1][1]}};
            b_d = {COLOR_W{bar_pipe_q[PIPE_LAT-1][0]}};
`else
            r_d = i_r;
            g_d = i_g;
            b_d = i_b;
`endif
        end
    end

    logic               hs_q, vs_q, de_q;
    logic [COLOR_W-1:0] r_q, g_q, b_q;

    always_ff @(posedge clk_vga) begin
        if (rst_vga) begin
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            de_q <= 1'b0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
        end else begin
            hs_q <= hs_pipe_q[PIPE_LAT-1];
            vs_q <= vs_pipe_q[PIPE_LAT-1];
            de_q <= de_last;
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
        end
    end

    assign o_vga_hs = hs_q;
    assign o_vga_vs = vs_q;
    assign o_vga_de = de_q;
    assign o_vga_r  = r_q;
    assign o_vga_g  = g_q;
    assign o_vga_b  = b_q;
endmodule
